// File: rtl/byte_frame_sequencer.sv
// Sequences a NUM_BYTES frame into a byte-wide UART transmitter, one trmt/tx_done
// handshake per byte, with a programmable idle gap between bytes.
module byte_frame_sequencer #(
    parameter int NUM_BYTES  = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_async,
    input  logic [8*NUM_BYTES-1:0] frame_data,
    input  logic                   tx_done,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int              IW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_BYTES - 1);
    localparam logic [15:0]     GAP_LOAD = 16'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ff1;
    logic          r_ff2;
    logic          r_ff3;
    logic          w_start_edge;
    logic [7:0]    r_shadow [NUM_BYTES];
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [IW-1:0] w_idx_inc;
    logic [15:0]   r_gap;
    logic [15:0]   w_gap_nxt;
    logic [7:0]    r_tx_data;
    logic [7:0]    w_tx_data_nxt;
    logic          r_overrun;
    logic          w_capture;

    // Flops reset high so a line already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff1 <= 1'b1;
            r_ff2 <= 1'b1;
            r_ff3 <= 1'b1;
        end else begin
            r_ff1 <= start_async;
            r_ff2 <= r_ff1;
            r_ff3 <= r_ff2;
        end
    end

    assign w_start_edge = r_ff2 & ~r_ff3;
    assign w_idx_inc    = r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_gap     <= '0;
            r_tx_data <= '0;
            r_overrun <= 1'b0;
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_gap     <= w_gap_nxt;
            r_tx_data <= w_tx_data_nxt;
            if (w_capture) begin
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    r_shadow[i] <= frame_data[8*i +: 8];
                end
            end
            if (w_capture) begin
                r_overrun <= 1'b0;
            end else if (w_start_edge && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // tx_data is only reloaded on the edge that enters SEND, so it holds through GAP.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_gap_nxt     = r_gap;
        w_tx_data_nxt = r_tx_data;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_capture     = 1'b1;
                    w_idx_nxt     = '0;
                    w_tx_data_nxt = frame_data[7:0];
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        if (GAP_CYCLES == 0) begin
                            w_tx_data_nxt = r_shadow[w_idx_inc];
                            w_state_nxt   = S_SEND;
                        end else begin
                            w_gap_nxt   = GAP_LOAD;
                            w_state_nxt = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                w_gap_nxt = r_gap - 1'b1;
                if (r_gap == 16'd1) begin
                    w_tx_data_nxt = r_shadow[r_idx];
                    w_state_nxt   = S_SEND;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign trmt       = (r_state == S_SEND);
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);
    assign tx_data    = r_tx_data;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_byte_frame_sequencer.sv
// Bench for byte_frame_sequencer: a GAP_CYCLES=16 build and a GAP_CYCLES=0 build,
// checked cycle by cycle against an arithmetic timeline of when each event must occur.
module tb_byte_frame_sequencer;
    localparam int NB  = 4;
    localparam int GAP = 16;

    typedef struct {
        logic [31:0] data;
        int          dly;        // tx_done delay after each trmt; 0 = random per byte
        bit          scramble;   // overwrite frame_data right after capture
        bit          restart;    // extra start edge while busy
        bit          spur;       // stray tx_done during a gap
        bit          sel;        // 0 = GAP_CYCLES=16 build, 1 = GAP_CYCLES=0 build
        logic [31:0] exp_bytes;  // expected bytes, byte 0 sent first from [7:0]
        bit          exp_ovr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic        tx_done_a, tx_done_b;
    logic [31:0] frame_data;
    logic        trmt_a, trmt_b, busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;
    logic [7:0]  data_a, data_b;

    bit          sel_m;
    logic        trmt_m, busy_m, done_m, ovr_m;
    logic [7:0]  data_m;

    int          cyc;
    int          n_cmp;
    int          n_err;

    always #5 clk = ~clk;

    byte_frame_sequencer #(.NUM_BYTES(NB), .GAP_CYCLES(GAP)) dut_a (
        .clk(clk), .rst(rst), .start_async(start_a), .frame_data(frame_data),
        .tx_done(tx_done_a), .trmt(trmt_a), .tx_data(data_a), .busy(busy_a),
        .frame_done(done_a), .overrun(ovr_a)
    );

    byte_frame_sequencer #(.NUM_BYTES(NB), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start_async(start_b), .frame_data(frame_data),
        .tx_done(tx_done_b), .trmt(trmt_b), .tx_data(data_b), .busy(busy_b),
        .frame_done(done_b), .overrun(ovr_b)
    );

    assign trmt_m = sel_m ? trmt_b : trmt_a;
    assign busy_m = sel_m ? busy_b : busy_a;
    assign done_m = sel_m ? done_b : done_a;
    assign ovr_m  = sel_m ? ovr_b  : ovr_a;
    assign data_m = sel_m ? data_b : data_a;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, build %0d)", name, act, exp, cyc, sel_m);
        end
    endtask

    task automatic drive_start(input bit s, input logic v);
        if (s) start_b = v;
        else   start_a = v;
    endtask

    task automatic drive_done(input bit s, input logic v);
        if (s) tx_done_b = v;
        else   tx_done_a = v;
    endtask

    // Timeline: start sampled at edge p+1 -> trmt T0=p+3; tx_done D_i=T_i+dly;
    // T_{i+1}=D_i+gap+1; frame_done F=D_last+1; busy over [T0,F].
    task automatic run_frame(input vec_t v);
        int         g, p, f, r, j;
        int         tt [NB];
        int         dd [NB];
        logic [7:0] eb;
        logic       exp_trmt, txd;
        sel_m = v.sel;
        g = v.sel ? 0 : GAP;
        drive_start(v.sel, 1'b0);
        repeat (3) tick();
        frame_data = v.data;
        drive_start(v.sel, 1'b1);
        p = cyc;
        tt[0] = p + 3;
        for (int i = 0; i < NB; i++) begin
            dd[i] = tt[i] + ((v.dly > 0) ? v.dly : int'($urandom_range(1, 40)));
            if (i < NB - 1) tt[i+1] = dd[i] + g + 1;
        end
        f = dd[NB-1] + 1;
        r = tt[0] + 2;
        j = -1;
        tick();
        while (cyc <= f + 2) begin
            txd      = 1'b0;
            exp_trmt = 1'b0;
            for (int i = 0; i < NB; i++) begin
                if (dd[i] == cyc) txd = 1'b1;
                if (tt[i] == cyc) exp_trmt = 1'b1;
                if (tt[i] <= cyc) j = i;
            end
            if (v.spur && g > 0 && cyc == dd[0] + 5) txd = 1'b1;
            drive_done(v.sel, txd);
            if (v.scramble && cyc == tt[0]) frame_data = 32'hDEADBEEF;
            if (v.restart && cyc == r)      drive_start(v.sel, 1'b0);
            if (v.restart && cyc == r + 1)  drive_start(v.sel, 1'b1);
            check("trmt", {31'b0, trmt_m}, {31'b0, exp_trmt});
            check("busy", {31'b0, busy_m}, {31'b0, (cyc >= tt[0] && cyc <= f)});
            check("frame_done", {31'b0, done_m}, {31'b0, (cyc == f)});
            if (j >= 0) begin
                eb = v.exp_bytes[8*j +: 8];
                check("tx_data", {24'b0, data_m}, {24'b0, eb});
            end
            if (cyc == tt[0]) check("overrun_clear", {31'b0, ovr_m}, 32'd0);
            tick();
        end
        drive_done(v.sel, 1'b0);
        check("overrun_end", {31'b0, ovr_m}, {31'b0, v.exp_ovr});
    endtask

    vec_t tbl [7];

    initial begin
        vec_t rv;
        int   p, d0, t1;
        tbl[0] = '{32'h44332211, 100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44332211, 1'b0};
        tbl[1] = '{32'h44332211,  20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h44332211, 1'b0};
        tbl[2] = '{32'hA5C3E781,  10, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5C3E781, 1'b1};
        tbl[3] = '{32'h0F1E2D3C,  12, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0F1E2D3C, 1'b0};
        tbl[4] = '{32'h44332211,  25, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44332211, 1'b0};
        tbl[5] = '{32'h44332211,   2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b0};
        tbl[6] = '{32'hCAFEF00D,   2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1};

        cyc = 0; n_cmp = 0; n_err = 0; sel_m = 1'b0;
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        tx_done_a = 1'b0; tx_done_b = 1'b0; frame_data = '0;
        repeat (3) tick();
        check("rst_tx_data_a", {24'b0, data_a}, 32'd0);
        check("rst_tx_data_b", {24'b0, data_b}, 32'd0);
        check("rst_frame_done", {30'b0, done_a, done_b}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("hi_at_reset_trmt", {30'b0, trmt_a, trmt_b}, 32'd0);
            check("hi_at_reset_busy", {30'b0, busy_a, busy_b}, 32'd0);
            check("hi_at_reset_ovr",  {30'b0, ovr_a, ovr_b},   32'd0);
        end

        for (int i = 0; i < 7; i++) run_frame(tbl[i]);

        // Reset in the middle of byte 1's WAIT, then a stray tx_done, then a clean restart.
        sel_m = 1'b0;
        start_a = 1'b0;
        repeat (3) tick();
        frame_data = 32'h44332211;
        start_a = 1'b1;
        p  = cyc;
        d0 = p + 3 + 30;
        t1 = d0 + GAP + 1;
        tick();
        while (cyc < t1 + 5) begin
            tx_done_a = (cyc == d0);
            tick();
        end
        tx_done_a = 1'b0;
        check("pre_rst_busy", {31'b0, busy_m}, 32'd1);
        check("pre_rst_tx_data", {24'b0, data_m}, 32'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_trmt", {31'b0, trmt_m}, 32'd0);
        check("mid_rst_busy", {31'b0, busy_m}, 32'd0);
        check("mid_rst_tx_data", {24'b0, data_m}, 32'd0);
        check("mid_rst_frame_done", {31'b0, done_m}, 32'd0);
        tx_done_a = 1'b1;
        tick();
        tx_done_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("post_rst_trmt", {31'b0, trmt_m}, 32'd0);
            check("post_rst_busy", {31'b0, busy_m}, 32'd0);
            tick();
        end
        run_frame(tbl[0]);

        for (int i = 0; i < 8; i++) begin
            rv.data      = $urandom;
            rv.dly       = 0;
            rv.sel       = 1'($urandom_range(0, 1));
            rv.scramble  = 1'($urandom_range(0, 1));
            rv.restart   = 1'($urandom_range(0, 1));
            rv.spur      = rv.sel ? 1'b0 : 1'($urandom_range(0, 1));
            rv.exp_bytes = rv.data;
            rv.exp_ovr   = rv.restart;
            run_frame(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
